// File: rtl/tdm_pkg.sv
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared constants, state type and channel-slice helper for
//                the 8-channel TDM demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_pkg;

    // Number of TDM channels and width of the slot index
    localparam int CH    = 8;
    localparam int SEL_W = 3;

    // Frame-alignment state: searching for SYNC, or aligned to the frame
    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bit offset of channel k inside a bus of W-bit channel slices
    function automatic int ch_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/slot_counter.sv
// ============================================================================
//  Module      : slot_counter
//  Description : Mod-8 slot index counter with synchronous clear-to-0 and
//                load-to-1, plus a terminal flag at the last slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load1,
    input  logic             clr,
    output logic [SEL_W-1:0] count,
    output logic             term
);

    // Clear wins over load, load wins over increment; wraps naturally mod 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load1) begin
            count <= SEL_W'(1);
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Terminal flag marks the slot whose sample completes a frame
    assign term = (count == SEL_W'(CH - 1));

endmodule

`default_nettype wire

// File: rtl/tdm_demux_1x8.sv
// ============================================================================
//  Module      : tdm_demux_1x8
//  Description : Receive end of an 8-channel TDM link. Serial samples are
//                collected into a shadow register and published as a whole
//                frame on O with a one-cycle FRAME_VALID pulse.
//  Options     : define TDM_DEMUX_SYNC_CHECK_EN to enable framing checks
//                (early / missing SYNC) and the SYNC_ERR pulse. Without it
//                the block flywheels once locked and SYNC_ERR is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter int W = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      DIN,
    input  logic              EN,
    input  logic              SYNC,
    output logic [CH*W-1:0]   O,
    output logic [SEL_W-1:0]  SEL,
    output logic              FRAME_VALID,
    output logic              LOCK,
    output logic              SYNC_ERR
);

    state_t                  state;
    state_t                  state_nxt;
    logic [(CH-1)*W-1:0]     shadow;     // slots 0..6; slot 7 goes straight to O
    logic [SEL_W-1:0]        sel;
    logic                    sel_term;

    logic                    wr_en;
    logic [SEL_W-1:0]        wr_slot;
    logic                    cnt_inc;
    logic                    cnt_load1;
    logic                    cnt_clr;
    logic                    publish;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic                    err;
    logic                    sync_err_q;
`endif

    slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_inc),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .count (sel),
        .term  (sel_term)
    );

    // Decode the action for this cycle from state, slot index and strobes
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_slot   = '0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
        publish   = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        err       = 1'b0;
`endif
        if (EN) begin
            case (state)
                HUNT: begin
                    if (SYNC) begin
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        cnt_load1 = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
                default: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    if (SYNC && (sel != '0)) begin
                        // Early SYNC: drop the partial frame, restart at slot 0
                        err       = 1'b1;
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        cnt_load1 = 1'b1;
                    end else if (!SYNC && (sel == '0)) begin
                        // Missing SYNC: alignment lost, go back to hunting
                        err       = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        cnt_inc = 1'b1;
                        if (sel_term) begin
                            publish = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_slot = sel;
                        end
                    end
`else
                    cnt_inc = 1'b1;
                    if (sel_term) begin
                        publish = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_slot = sel;
                    end
`endif
                end
            endcase
        end
    end

    // Frame-alignment state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Shadow register collects slots 0..6 of the frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[ch_off(int'(wr_slot), W) +: W] <= DIN;
        end
    end

    // Whole-frame publish: slot 7 sample joins the shadow in one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O           <= '0;
            FRAME_VALID <= 1'b0;
        end else begin
            FRAME_VALID <= publish;
            if (publish) begin
                O <= {DIN, shadow};
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    // Framing-error pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= err;
        end
    end
    assign SYNC_ERR = sync_err_q;
`else
    assign SYNC_ERR = 1'b0;
`endif

    assign SEL  = sel;
    assign LOCK = (state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1x8.sv
// ============================================================================
//  Module      : tb_tdm_demux_1x8
//  Description : Directed self-checking bench for tdm_demux_1x8 (W=1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x8;

    logic       clk;
    logic       rst_n;
    logic [0:0] DIN;
    logic       EN;
    logic       SYNC;
    logic [7:0] O;
    logic [2:0] SEL;
    logic       FRAME_VALID;
    logic       LOCK;
    logic       SYNC_ERR;

    int passed;
    int failed;
    int cyc;
    int fv_count;
    int fv_last;
    int fv_gap;
    int fv_before;

    tdm_demux_1x8 #(.W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DIN         (DIN),
        .EN          (EN),
        .SYNC        (SYNC),
        .O           (O),
        .SEL         (SEL),
        .FRAME_VALID (FRAME_VALID),
        .LOCK        (LOCK),
        .SYNC_ERR    (SYNC_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One EN sample, then sample outputs 1 time unit after the edge
    task automatic send(input logic d, input logic s);
        EN   = 1'b1;
        DIN  = d;
        SYNC = s;
        @(posedge clk);
        #1;
        EN   = 1'b0;
        SYNC = 1'b0;
        if (FRAME_VALID === 1'b1) begin
            fv_count = fv_count + 1;
            fv_gap   = cyc - fv_last;
            fv_last  = cyc;
        end
    endtask

    task automatic idle();
        EN   = 1'b0;
        SYNC = 1'b1;   // SYNC while EN=0 must be ignored
        @(posedge clk);
        #1;
        SYNC = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send(b[i], i == 0);
    endtask

    initial begin
        logic [7:0] v;
        passed = 0; failed = 0; cyc = 0;
        fv_count = 0; fv_last = 0; fv_gap = 0;
        rst_n = 1'b1; EN = 1'b0; DIN = 1'b0; SYNC = 1'b0;

        // Asynchronous reset mid-cycle, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst_O", O, 8'h00);
        check("rst_SEL", SEL, 0);
        check("rst_LOCK", LOCK, 0);
        check("rst_FV", FRAME_VALID, 0);
        check("rst_ERR", SYNC_ERR, 0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame 8'hAB
        v = 8'hAB;
        send(v[0], 1'b1);
        check("basic_lock", LOCK, 1);
        check("basic_sel1", SEL, 1);
        for (int i = 1; i < 8; i++) send(v[i], 1'b0);
        check("basic_O", O, 8'hAB);
        check("basic_FV", FRAME_VALID, 1);
        check("basic_sel0", SEL, 0);
        check("basic_fvcnt", fv_count, 1);

        // Back-to-back frame 8'hA0, EN held high
        v = 8'hA0;
        send(v[0], 1'b1);
        check("b2b_fv_low", FRAME_VALID, 0);
        check("b2b_O_hold", O, 8'hAB);
        for (int i = 1; i < 8; i++) send(v[i], 1'b0);
        check("b2b_O", O, 8'hA0);
        check("b2b_gap", fv_gap, 8);
        check("b2b_fvcnt", fv_count, 2);

        // EN gaps across frame 8'h5A; SEL holds while EN=0
        v = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            send(v[i], i == 0);
            if (i < 7) begin
                idle();
                check("gap_sel_hold", SEL, i + 1);
                check("gap_fv_low", FRAME_VALID, 0);
            end
        end
        check("gap_O", O, 8'h5A);
        check("gap_FV", FRAME_VALID, 1);

        // Mid-operation reset loses the partial frame
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_O", O, 8'h00);
        check("mid_rst_LOCK", LOCK, 0);
        check("mid_rst_SEL", SEL, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // HUNT discards samples without SYNC
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
        check("hunt_lock", LOCK, 0);
        check("hunt_sel", SEL, 0);
        check("hunt_O", O, 8'h00);
        send_byte(8'h3C);
        check("hunt_relock_O", O, 8'h3C);
        check("hunt_relock_FV", FRAME_VALID, 1);

        // Early SYNC at slot 4
        fv_before = fv_count;
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
        send(1'b1, 1'b1);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        check("early_err", SYNC_ERR, 1);
        check("early_fv", FRAME_VALID, 0);
        check("early_sel", SEL, 1);
        send(1'b0, 1'b0);
        check("early_err_clr", SYNC_ERR, 0);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
        send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
        check("early_O", O, 8'hAD);
`else
        check("early_err", SYNC_ERR, 0);
        check("early_sel", SEL, 5);
        send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        check("early_O", O, 8'hD9);
`endif
        check("early_FV", FRAME_VALID, 1);
        check("early_fvcnt", fv_count - fv_before, 1);

        // Missing SYNC on slot 0
        send(1'b1, 1'b0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        check("miss_err", SYNC_ERR, 1);
        check("miss_lock", LOCK, 0);
        check("miss_sel", SEL, 0);
        send_byte(8'h96);
        check("miss_relock", LOCK, 1);
        check("miss_O", O, 8'h96);
`else
        check("miss_err", SYNC_ERR, 0);
        check("miss_lock", LOCK, 1);
        check("miss_sel", SEL, 1);
        v = 8'h96;
        for (int i = 1; i < 8; i++) send(v[i], 1'b0);
        check("miss_O", O, 8'h97);
`endif
        check("miss_FV", FRAME_VALID, 1);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux_1x8.md
# tdm_demux_1x8

Time-division 1-to-8 demultiplexer: the receive end of an 8-channel TDM link whose transmit end is the 8:1 multiplexer.
- A serial sample stream, marked at slot 0 by a frame-sync strobe, is distributed into eight channel slots.
- Each completed frame is presented in parallel on the output bus, with a one-cycle valid pulse.
- The block sits directly after the link input and feeds per-channel consumers.

## Interface
- W, default 1, bits per channel sample.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- DIN  input  W  serial sample for the current slot.
- EN  input  1  sample strobe; DIN and SYNC are valid only when EN=1.
- SYNC  input  1  frame marker; high together with EN on the slot-0 sample.
- O  output  8*W  last complete frame; channel k is O[k*W +: W].
- SEL  output  3  slot index the next EN sample is written to.
- FRAME_VALID  output  1  one-cycle pulse when O carries a new frame.
- LOCK  output  1  high while the block is frame-locked.
- SYNC_ERR  output  1  one-cycle pulse on a framing violation; tied 0 when the check is compiled out.

## Operation
- Reset (rst_n=0, asynchronous): state HUNT; O, shadow register, SEL, FRAME_VALID, LOCK and SYNC_ERR all 0.
- EN=0: all state holds; pulse outputs are 0.
- Two states:
  - HUNT (LOCK=0): SEL held at 0 and samples are discarded until EN&SYNC. On EN&SYNC, DIN is written to shadow slot 0, SEL becomes 1 and the state moves to LOCKED.
  - LOCKED (LOCK=1): on each EN, DIN is written to shadow[SEL] and SEL advances by 1, mod 8.
- Frame completion: on EN with SEL=7:
  - O is loaded with {DIN, shadow[6:0]}.
  - FRAME_VALID is high for the following cycle.
  - SEL wraps to 0.
- A frame is never partially published. Channels not yet written in the current frame keep their previous-frame shadow values but are not visible until completion.
- Mid-operation reset: the partial frame is lost, O returns to 0 and the block re-enters HUNT.

## Timing
- Latency: O and FRAME_VALID update on the same clock edge that samples slot 7. Both are registered, with no combinational path from DIN to O.
- Back-to-back frames are allowed: EN may stay high continuously, giving a FRAME_VALID every 8 cycles.
- SEL, LOCK and SYNC_ERR are registered and change only on clock edges.
- A SYNC seen while EN=0 is ignored.

## Configuration
- Macro: TDM_DEMUX_SYNC_CHECK_EN.
- Defined:
  - EN&SYNC with SEL≠0 in LOCKED: SYNC_ERR pulses for one cycle and the partial frame is abandoned with no FRAME_VALID. The sample is taken as a new slot 0 and SEL becomes 1.
  - EN with SEL=0 and SYNC=0 in LOCKED: SYNC_ERR pulses, the sample is dropped, and the state returns to HUNT (LOCK=0).
- Undefined (flywheel mode):
  - SYNC is ignored in LOCKED, and the slot counter free-runs once locked.
  - SYNC_ERR is constant 0.
  - Only reset returns the block to HUNT.

## Structure
- Package tdm_pkg holds:
  - CH=8 and SEL_W=3.
  - The state type {HUNT, LOCKED}.
  - The channel-slice helper (index k → bit offset k*W).
- Sub-module slot_counter (3-bit, mod-8) has:
  - inputs: enable, synchronous load-to-1, clear-to-0;
  - outputs: count and a terminal flag at count 7.
- The FSM, shadow register and output register live in tdm_demux_1x8.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle → O=8'h00, SEL=0, LOCK=0, FRAME_VALID=0 immediately.
- Basic frame, W=1: send EN=1 with SYNC on the first sample, DIN=bits 0..7 of 8'hAB in slot order. Required response: LOCK=1 after the first edge, O=8'hAB with a single FRAME_VALID pulse after the 8th edge, SEL back at 0.
- Back-to-back: frame 8'hAB then 8'hA0 with EN held high. Required response: FRAME_VALID pulses exactly 8 cycles apart, O=8'hAB then 8'hA0.
- EN gaps and HUNT discard:
  - EN toggled 1/0 across a frame of 8'h5A → same result as the basic frame, and SEL holds during EN=0.
  - Samples sent in HUNT without SYNC → discarded, LOCK stays 0.
- Early SYNC (macro defined): SYNC at slot 4 → SYNC_ERR pulse, no FRAME_VALID, SEL=1. The next 7 samples complete a new frame. With the macro undefined, the same stimulus gives no SYNC_ERR and the frame completes on the original alignment.
- Missing SYNC (macro defined): slot-0 sample sent without SYNC → SYNC_ERR pulse, LOCK=0. A subsequent EN&SYNC relocks.
